// File: rtl/archie_mem_pkg.sv
// Shared definitions for the Archimedes SDRAM port arbiter: the FSM state
// type, wishbone cycle-type codes and the default loader base address.
package archie_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CORE  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_FLUSH = 2'd3
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [25:0] LOAD_BASE_DEFAULT = 26'h400000;

endpackage

// File: rtl/archie_dl_packer.sv
// Loader holding register. Captures HPS loader words and presents one pending
// SDRAM write (word index, data, byte selects) to the arbiter FSM.
// With ARCHIE_LOADER_PACK_EN defined, low half-words are held and merged with
// the following high half into one 32-bit write; a stranded low half is
// raised as a flush write.
module archie_dl_packer
  import archie_mem_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [15:0] dl_data,
  input  logic        wr_done,
  output logic        pending,
  output logic        flush,
  output logic [21:0] adr,
  output logic [31:0] dat,
  output logic [3:0]  sel
);

  logic        pend_q, pend_d;
  logic        flush_q, flush_d;
  logic [21:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [1:0]  unused_addr_bits;

  // Only the 32-bit word index inside a 16 MiB window is used.
  assign unused_addr_bits = {dl_addr[24], dl_addr[0]};

`ifdef ARCHIE_LOADER_PACK_EN
  logic        lo_vld_q, lo_vld_d;
  logic [21:0] lo_adr_q, lo_adr_d;
  logic [15:0] lo_dat_q, lo_dat_d;

  // Pack half-words; flush an old low half on a word change or end of download.
  always_comb begin
    pend_d   = pend_q;
    flush_d  = flush_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    lo_vld_d = lo_vld_q;
    lo_adr_d = lo_adr_q;
    lo_dat_d = lo_dat_q;
    if (pend_q) begin
      if (wr_done) begin
        pend_d  = 1'b0;
        flush_d = 1'b0;
      end
    end else if (dl_wr) begin
      if (dl_addr[1]) begin
        pend_d  = 1'b1;
        flush_d = 1'b0;
        adr_d   = dl_addr[23:2];
        if (lo_vld_q && (lo_adr_q == dl_addr[23:2])) begin
          dat_d    = {dl_data, lo_dat_q};
          sel_d    = 4'b1111;
          lo_vld_d = 1'b0;
        end else begin
          dat_d = {dl_data, dl_data};
          sel_d = 4'b1100;
        end
      end else begin
        // A low half for a different word pushes the held one out first.
        if (lo_vld_q && (lo_adr_q != dl_addr[23:2])) begin
          pend_d  = 1'b1;
          flush_d = 1'b1;
          adr_d   = lo_adr_q;
          dat_d   = {lo_dat_q, lo_dat_q};
          sel_d   = 4'b0011;
        end
        lo_vld_d = 1'b1;
        lo_adr_d = dl_addr[23:2];
        lo_dat_d = dl_data;
      end
    end else if (lo_vld_q && !dl_active) begin
      pend_d   = 1'b1;
      flush_d  = 1'b1;
      adr_d    = lo_adr_q;
      dat_d    = {lo_dat_q, lo_dat_q};
      sel_d    = 4'b0011;
      lo_vld_d = 1'b0;
    end
  end

  // Held low-half payload; qualified by lo_vld_q so it needs no reset.
  always_ff @(posedge clk_sys) begin
    lo_adr_q <= lo_adr_d;
    lo_dat_q <= lo_dat_d;
  end

  // Low-half valid flag; reset discards a half-packed word.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) lo_vld_q <= 1'b0;
    else          lo_vld_q <= lo_vld_d;
  end
`else
  logic unused_dl_active;

  assign unused_dl_active = dl_active;

  // One SDRAM write per loader word; the half is mirrored into both lanes.
  always_comb begin
    pend_d  = pend_q;
    flush_d = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    if (pend_q) begin
      if (wr_done) pend_d = 1'b0;
    end else if (dl_wr) begin
      pend_d = 1'b1;
      adr_d  = dl_addr[23:2];
      dat_d  = {dl_data, dl_data};
      sel_d  = dl_addr[1] ? 4'b1100 : 4'b0011;
    end
  end
`endif

  // Pending-write control flags; reset drops any queued write.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      flush_q <= flush_d;
    end
  end

  // Pending-write payload; only observed while pend_q is set.
  always_ff @(posedge clk_sys) begin
    adr_q <= adr_d;
    dat_q <= dat_d;
    sel_q <= sel_d;
  end

  assign pending = pend_q;
  assign flush   = flush_q;
  assign adr     = adr_q;
  assign dat     = dat_q;
  assign sel     = sel_q;

endmodule

// File: rtl/archie_mem_arbiter.sv
// Arbitrates the single SDRAM wishbone port between the Archimedes core and
// the HPS ROM loader. Core cycles are passed through combinationally and the
// grant is held for the whole burst; loader writes are registered single
// writes paced by dl_wait. Define ARCHIE_LOADER_PACK_EN to pack 16-bit loader
// words into 32-bit writes (adds the FLUSH state).
module archie_mem_arbiter
  import archie_mem_pkg::*;
#(
  parameter int               ADR_W     = 26,
  parameter logic [ADR_W-1:0] LOAD_BASE = ADR_W'(LOAD_BASE_DEFAULT)
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             dl_active,
  input  logic             dl_wr,
  input  logic [24:0]      dl_addr,
  input  logic [15:0]      dl_data,
  output logic             dl_wait,
  input  logic             core_cyc,
  input  logic             core_stb,
  input  logic             core_we,
  input  logic [3:0]       core_sel,
  input  logic [2:0]       core_cti,
  input  logic [24:0]      core_adr,
  input  logic [31:0]      core_dat,
  output logic             core_ack,
  output logic             ram_cyc,
  output logic             ram_stb,
  output logic             ram_we,
  output logic [3:0]       ram_sel,
  output logic [2:0]       ram_cti,
  output logic [ADR_W-1:0] ram_adr,
  output logic [31:0]      ram_dat,
  input  logic             ram_ack
);

  arb_state_t       state_q, state_d;
  logic [ADR_W-1:0] ld_adr_q, ld_adr_d;
  logic             pk_pending, pk_flush, wr_done;
  logic [21:0]      pk_adr;
  logic [31:0]      pk_dat;
  logic [3:0]       pk_sel;
  logic             unused_core_adr_msb;

  assign unused_core_adr_msb = core_adr[24];

  assign wr_done = ram_ack && ((state_q == ST_LOAD) || (state_q == ST_FLUSH));

  archie_dl_packer u_packer (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .wr_done   (wr_done),
    .pending   (pk_pending),
    .flush     (pk_flush),
    .adr       (pk_adr),
    .dat       (pk_dat),
    .sel       (pk_sel)
  );

  // Next-state logic: loader wins in IDLE, core grant held until end of burst.
  always_comb begin
    state_d  = state_q;
    ld_adr_d = ld_adr_q;
    case (state_q)
      ST_IDLE: begin
        if (pk_pending) begin
          ld_adr_d = LOAD_BASE + ADR_W'({pk_adr, 2'b00});
`ifdef ARCHIE_LOADER_PACK_EN
          state_d = pk_flush ? ST_FLUSH : ST_LOAD;
`else
          state_d = ST_LOAD;
`endif
        end else if (core_cyc && core_stb && !dl_active) begin
          state_d = ST_CORE;
        end
      end
      ST_CORE: begin
        if (!core_cyc ||
            (ram_ack && ((core_cti == CTI_EOB) || (core_cti == CTI_CLASSIC)))) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (ram_ack) state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register; reset returns to IDLE at once.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Loader target address, captured on entry to LOAD/FLUSH.
  always_ff @(posedge clk_sys) begin
    ld_adr_q <= ld_adr_d;
  end

  // Output mux: core passthrough in CORE, registered loader write otherwise.
  always_comb begin
    ram_cyc = 1'b0;
    ram_stb = 1'b0;
    ram_we  = 1'b0;
    ram_sel = 4'b0000;
    ram_cti = CTI_CLASSIC;
    ram_adr = '0;
    ram_dat = 32'h0;
    case (state_q)
      ST_CORE: begin
        ram_cyc = core_cyc;
        ram_stb = core_stb;
        ram_we  = core_we;
        ram_sel = core_sel;
        ram_cti = core_cti;
        ram_adr = ADR_W'({core_adr[23:0], 2'b00});
        ram_dat = core_dat;
      end
      ST_LOAD, ST_FLUSH: begin
        ram_cyc = 1'b1;
        ram_stb = 1'b1;
        ram_we  = 1'b1;
        ram_sel = pk_sel;
        ram_cti = CTI_CLASSIC;
        ram_adr = ld_adr_q;
        ram_dat = pk_dat;
      end
      default: ;
    endcase
  end

  assign core_ack = ram_ack && (state_q == ST_CORE);
  assign dl_wait  = pk_pending;

`ifndef ARCHIE_LOADER_PACK_EN
  logic unused_pk_flush;
  assign unused_pk_flush = pk_flush;
`endif

endmodule

// File: tb/tb_archie_mem_arbiter.sv
// Directed bench for archie_mem_arbiter: reset values, core burst hold,
// dl_active blocking, loader writes (packed or unpacked build), loader
// priority and reset during a loader write.
module tb_archie_mem_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [15:0] dl_data = '0;
  logic        dl_wait;
  logic        core_cyc = 1'b0;
  logic        core_stb = 1'b0;
  logic        core_we = 1'b0;
  logic [3:0]  core_sel = 4'h0;
  logic [2:0]  core_cti = 3'b000;
  logic [24:0] core_adr = '0;
  logic [31:0] core_dat = '0;
  logic        core_ack;
  logic        ram_cyc;
  logic        ram_stb;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [2:0]  ram_cti;
  logic [25:0] ram_adr;
  logic [31:0] ram_dat;
  logic        ram_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int acks   = 0;

  archie_mem_arbiter dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .dl_wait   (dl_wait),
    .core_cyc  (core_cyc),
    .core_stb  (core_stb),
    .core_we   (core_we),
    .core_sel  (core_sel),
    .core_cti  (core_cti),
    .core_adr  (core_adr),
    .core_dat  (core_dat),
    .core_ack  (core_ack),
    .ram_cyc   (ram_cyc),
    .ram_stb   (ram_stb),
    .ram_we    (ram_we),
    .ram_sel   (ram_sel),
    .ram_cti   (ram_cti),
    .ram_adr   (ram_adr),
    .ram_dat   (ram_dat),
    .ram_ack   (ram_ack)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cyc"}, 64'(ram_cyc), 64'd0);
    chk({tag, "_stb"}, 64'(ram_stb), 64'd0);
    chk({tag, "_we"},  64'(ram_we),  64'd0);
    chk({tag, "_sel"}, 64'(ram_sel), 64'd0);
    chk({tag, "_cti"}, 64'(ram_cti), 64'd0);
    chk({tag, "_adr"}, 64'(ram_adr), 64'd0);
    chk({tag, "_dat"}, 64'(ram_dat), 64'd0);
    chk({tag, "_ack"}, 64'(core_ack), 64'd0);
    chk({tag, "_wait"}, 64'(dl_wait), 64'd0);
  endtask

  initial begin
    // Power-on reset values.
    #1 reset_n = 1'b0;
    #1 chk_all_zero("rst");
    step(); step();
    reset_n = 1'b1;

    // Core burst 010,010,010,111 with an ack on every beat.
    step();
    core_cyc = 1'b1; core_stb = 1'b1; core_we = 1'b1; core_sel = 4'hF;
    core_cti = 3'b010; core_adr = 25'h100; core_dat = 32'hCAFE_0001;
    #2 chk("burst_pre_grant_cyc", 64'(ram_cyc), 64'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      core_cti = (i == 3) ? 3'b111 : 3'b010;
      ram_ack  = 1'b1;
      #2 chk("burst_cyc_held", 64'(ram_cyc), 64'd1);
      if (core_ack) acks++;
      step();
    end
    chk("burst_ack_count", 64'(acks), 64'd4);
    chk("burst_dat_pass", 64'(ram_dat), 64'd0);
    ram_ack = 1'b0;
    #2 chk("burst_back_idle_cyc", 64'(ram_cyc), 64'd0);
    core_cyc = 1'b0; core_stb = 1'b0; core_we = 1'b0;

    // dl_active rises mid-burst: burst completes, no new grant meanwhile.
    step();
    core_cyc = 1'b1; core_stb = 1'b1; core_cti = 3'b010; core_sel = 4'h3;
    step();
    for (int i = 0; i < 4; i++) begin
      dl_active = (i >= 1);
      core_cti  = (i == 3) ? 3'b111 : 3'b010;
      ram_ack   = 1'b1;
      #2 chk("midburst_core_ack", 64'(core_ack), 64'd1);
      chk("midburst_sel_pass", 64'(ram_sel), 64'h3);
      step();
    end
    ram_ack = 1'b0; core_cti = 3'b010;
    #2 chk("blocked_cyc_a", 64'(ram_cyc), 64'd0);
    step();
    ram_ack = 1'b1;
    #2 chk("blocked_cyc_b", 64'(ram_cyc), 64'd0);
    chk("blocked_core_ack", 64'(core_ack), 64'd0);
    step();
    ram_ack = 1'b0; dl_active = 1'b0;
    #2 chk("blocked_cyc_c", 64'(ram_cyc), 64'd0);
    step();
    #2 chk("regrant_cyc", 64'(ram_cyc), 64'd1);
    core_cyc = 1'b0; core_stb = 1'b0;
    #1 chk("cyc_fall_pass", 64'(ram_cyc), 64'd0);
    step();

`ifndef ARCHIE_LOADER_PACK_EN
    // Unpacked loader: 0xBEEF at offset 0x6.
    dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 25'h6; dl_data = 16'hBEEF;
    #2 chk("ld_wait_T", 64'(dl_wait), 64'd0);
    step();
    dl_addr = 25'h10; dl_data = 16'h1234;
    #2 chk("ld_wait_T1", 64'(dl_wait), 64'd1);
    chk("ld_cyc_T1", 64'(ram_cyc), 64'd0);
    step();
    dl_wr = 1'b0;
    #2 chk("ld_cyc", 64'(ram_cyc), 64'd1);
    chk("ld_we", 64'(ram_we), 64'd1);
    chk("ld_cti", 64'(ram_cti), 64'd0);
    chk("ld_adr", 64'(ram_adr), 64'h400004);
    chk("ld_sel", 64'(ram_sel), 64'hC);
    chk("ld_dat", 64'(ram_dat), 64'hBEEFBEEF);
    chk("ld_wait_T2", 64'(dl_wait), 64'd1);
    step();
    ram_ack = 1'b1;
    #2 chk("ld_no_core_ack", 64'(core_ack), 64'd0);
    chk("ld_wait_ack", 64'(dl_wait), 64'd1);
    step();
    ram_ack = 1'b0;
    #2 chk("ld_wait_after", 64'(dl_wait), 64'd0);
    chk("ld_cyc_after", 64'(ram_cyc), 64'd0);
    step();
    dl_wr = 1'b1; dl_addr = 25'h1; dl_data = 16'hA5A5;
    step();
    dl_wr = 1'b0;
    step();
    #2 chk("ld_lo_adr", 64'(ram_adr), 64'h400000);
    chk("ld_lo_sel", 64'(ram_sel), 64'h3);
    chk("ld_lo_dat", 64'(ram_dat), 64'hA5A5A5A5);
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
`else
    // Packed loader: two halves make exactly one write.
    dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 25'h0; dl_data = 16'h1111;
    step();
    dl_wr = 1'b0;
    #2 chk("pk_wait_lo", 64'(dl_wait), 64'd0);
    chk("pk_cyc_lo", 64'(ram_cyc), 64'd0);
    step();
    #2 chk("pk_cyc_lo2", 64'(ram_cyc), 64'd0);
    dl_wr = 1'b1; dl_addr = 25'h2; dl_data = 16'h2222;
    step();
    dl_wr = 1'b0;
    #2 chk("pk_wait_hi", 64'(dl_wait), 64'd1);
    step();
    #2 chk("pk_cyc", 64'(ram_cyc), 64'd1);
    chk("pk_adr", 64'(ram_adr), 64'h400000);
    chk("pk_sel", 64'(ram_sel), 64'hF);
    chk("pk_dat", 64'(ram_dat), 64'h22221111);
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    #2 chk("pk_wait_after", 64'(dl_wait), 64'd0);
    chk("pk_cyc_after", 64'(ram_cyc), 64'd0);
    step();
    #2 chk("pk_single_write", 64'(ram_cyc), 64'd0);
    // Packed tail flushed when dl_active falls.
    dl_wr = 1'b1; dl_addr = 25'h8; dl_data = 16'h3333;
    step();
    dl_wr = 1'b0;
    #2 chk("tail_wait_lo", 64'(dl_wait), 64'd0);
    step();
    #2 chk("tail_no_write", 64'(ram_cyc), 64'd0);
    dl_active = 1'b0;
    step();
    #2 chk("tail_wait", 64'(dl_wait), 64'd1);
    step();
    #2 chk("tail_cyc", 64'(ram_cyc), 64'd1);
    chk("tail_adr", 64'(ram_adr), 64'h400008);
    chk("tail_sel", 64'(ram_sel), 64'h3);
    chk("tail_dat_lo", 64'(ram_dat[15:0]), 64'h3333);
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    #2 chk("tail_cyc_after", 64'(ram_cyc), 64'd0);
    chk("tail_wait_after", 64'(dl_wait), 64'd0);
`endif

    // Loader has priority over a simultaneous core request.
    step();
    dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 25'h6; dl_data = 16'h5A5A;
    step();
    dl_wr = 1'b0; dl_active = 1'b0; core_cyc = 1'b1; core_stb = 1'b1; core_we = 1'b0;
    step();
    #2 chk("prio_we", 64'(ram_we), 64'd1);
    chk("prio_adr", 64'(ram_adr), 64'h400004);
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    #2 chk("prio_idle_cyc", 64'(ram_cyc), 64'd0);
    step();
    #2 chk("prio_core_cyc", 64'(ram_cyc), 64'd1);
    chk("prio_core_we", 64'(ram_we), 64'd0);
    core_cyc = 1'b0; core_stb = 1'b0;
    step();

    // Reset while a loader write awaits its ack.
    dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 25'h6; dl_data = 16'hBEEF;
    step();
    dl_wr = 1'b0;
    step();
    #2 chk("rstld_cyc_before", 64'(ram_cyc), 64'd1);
    reset_n = 1'b0;
    #1 chk_all_zero("rstld");
    step(); step();
    reset_n = 1'b1; dl_active = 1'b0;
    step();
    #2 chk("rstld_idle_cyc", 64'(ram_cyc), 64'd0);
    chk("rstld_idle_wait", 64'(dl_wait), 64'd0);
    core_cyc = 1'b1; core_stb = 1'b1;
    step();
    #2 chk("rstld_core_grant", 64'(ram_cyc), 64'd1);
    core_cyc = 1'b0; core_stb = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
